mpc_sram_1r1w_be: RTL and testbench
===================================

# mpc_sram_1r1w_be

Parametrised one-read/one-write SRAM macro model with byte-lane write enables, write-first same-address bypass, an optional output pipeline register and a hardware zero-initialisation sequencer. It is the next-generation storage primitive for MPC tables and buffers that need concurrent read and write ports, partial-word updates and known contents after reset without a software clear pass.

## Interface
- ADDR_SIZE, 6: address width in bits.
- DATA_SIZE, 64: word width in bits. Must be a multiple of 8.
- DEPTH, 2**ADDR_SIZE: number of words. Must be ≤ 2**ADDR_SIZE.
- BE_SIZE, DATA_SIZE/8: byte-lane count (derived, not overridden).
- OUT_REG, 0: 0 = 1-cycle read latency, 1 = 2-cycle read latency with an extra output register.
- INIT_ON_RESET, 1: 1 = zero every word after reset release, 0 = no clear.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_done  out  1  array usable; requests are ignored while low.
- rd_cs  in  1  read request.
- rd_addr  in  ADDR_SIZE  read address.
- rdata  out  DATA_SIZE  read data.
- rvalid  out  1  rdata carries the result of a read request this cycle.
- wr_cs  in  1  write request.
- wr_addr  in  ADDR_SIZE  write address.
- wr_be  in  BE_SIZE  byte enables; bit i covers wdata[8i+7:8i].
- wdata  in  DATA_SIZE  write data.

## Operation
- FSM states: INIT and READY. Reset puts the FSM in INIT with clear counter cnt = 0.
- INIT with INIT_ON_RESET=1: each rising edge writes all-zero to mem[cnt] and increments cnt. The edge that writes DEPTH-1 moves the FSM to READY and sets init_done.
- INIT with INIT_ON_RESET=0: the first edge after reset release moves the FSM to READY with no writes.
- While not in READY, rd_cs and wr_cs are ignored: no array write, no rvalid.
- Write (READY, wr_cs=1): for each i with wr_be[i]=1, byte i of mem[wr_addr] takes wdata byte i. Other bytes are unchanged. wr_be=0 is a no-op.
- Read (READY, rd_cs=1): returns mem[rd_addr].
- Same-address read and write in the same cycle are write-first. Returned data is the merged word: new bytes on enabled lanes, old bytes elsewhere.
- Reads and writes to different addresses are fully independent.
- Addresses ≥ DEPTH: writes are dropped and reads return 0 with rvalid asserted.
- rdata holds its last value when no read completes. rvalid is a one-cycle pulse per read and is never stretched.
- Async rst_n assertion at any time (including mid-INIT or with reads in the pipeline):
  - flushes pending reads (rvalid=0);
  - returns the FSM to INIT with cnt=0 and clears init_done;
  - restarts the full clear sequence on release.
- Array contents are not reset directly; only the INIT sequence clears them.

## Timing
- Reset values: init_done=0, rvalid=0, rdata=0. The output register, if present, is also 0.
- init_done latency:
  - INIT_ON_RESET=1: rises after the DEPTH-th rising edge following rst_n release.
  - INIT_ON_RESET=0: rises after the 1st edge.
- A request sampled at edge N is accepted only if init_done=1 before edge N.
- Read latency:
  - OUT_REG=0: rdata and rvalid are valid in the cycle after edge N (registered at N).
  - OUT_REG=1: valid one cycle later (registered at N+1). Fully pipelined, one read per cycle.
- Write at edge N is visible to a different-cycle read sampled at edge N+1 or later. Same-cycle visibility is via the bypass.
- No backpressure: every accepted read produces exactly one rvalid pulse at a fixed latency.

## Test plan
- Reset release, DEPTH=64, INIT_ON_RESET=1, rd_cs held 1 throughout:
  - init_done rises after exactly 64 edges;
  - no rvalid before that;
  - reading all 64 addresses afterwards returns 0.
- Write addr 5 wdata=0x1122334455667788 wr_be=0xFF, then read addr 5:
  - rdata=0x1122334455667788 one cycle later (OUT_REG=0), two cycles later (OUT_REG=1).
- Then write addr 5 wdata=0xAAAAAAAAAAAAAAAA wr_be=0x0F, with a same-cycle read of addr 5:
  - rdata=0x11223344AAAAAAAA (bypass merge);
  - a later read returns the same value.
- Back-to-back reads of addr 0..63 on consecutive cycles while writing addr 63..0:
  - one rvalid per read at fixed latency;
  - each returns the pre-write or bypassed value per the same-cycle rule.
- Assert rst_n at cnt=30 mid-INIT, release:
  - init_done stays 0 for a fresh 64 edges;
  - data written before the reset reads back 0 afterwards.
- DEPTH=48, ADDR_SIZE=6: write addr 50, then read addr 50 -> rdata=0, rvalid=1, no alias write to addr 2 or any other address.

Source files
------------

// File: rtl/mpc_sram_1r1w_be.sv
`default_nettype none
// ============================================================================
// Module   : mpc_sram_1r1w_be
// Purpose  : One-read/one-write SRAM macro model with byte-lane write enables,
//            write-first same-address bypass, an optional output pipeline
//            register and a zero-initialisation sequencer that clears every
//            word after reset release.
// Ports    : clk        - clock, all state on the rising edge
//            rst_n      - asynchronous active-low reset
//            init_done  - array usable; requests ignored while low
//            rd_cs      - read request
//            rd_addr    - read address
//            rdata      - read data (holds between reads)
//            rvalid     - one-cycle pulse per completed read
//            wr_cs      - write request
//            wr_addr    - write address
//            wr_be      - byte enables, bit i covers wdata[8i+7:8i]
//            wdata      - write data
// Revision : 1.0 - initial release
// ============================================================================
module mpc_sram_1r1w_be #(
  parameter  int ADDR_SIZE     = 6,
  parameter  int DATA_SIZE     = 64,
  parameter  int DEPTH         = 2**ADDR_SIZE,
  parameter  int OUT_REG       = 0,
  parameter  int INIT_ON_RESET = 1,
  localparam int BE_SIZE       = DATA_SIZE / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 init_done,
  input  logic                 rd_cs,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rvalid,
  input  logic                 wr_cs,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [BE_SIZE-1:0]   wr_be,
  input  logic [DATA_SIZE-1:0] wdata
);

  // Addresses are widened by one bit before comparing against DEPTH so that
  // DEPTH == 2**ADDR_SIZE is representable.
  localparam logic [ADDR_SIZE:0]   c_depth = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE-1:0] c_last  = ADDR_SIZE'(DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] c_one   = ADDR_SIZE'(1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_SIZE-1:0] r_cnt;
  logic [ADDR_SIZE-1:0] w_cnt_nxt;
  logic                 w_init_we;

  logic                 w_ready;
  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic                 w_same_addr;
  logic [DATA_SIZE-1:0] w_rd_word;

  logic [DATA_SIZE-1:0] r_mem [DEPTH];

  logic                 r_rd_valid;
  logic [DATA_SIZE-1:0] r_rd_data;

  // --------------------------------------------------------------------------
  // Init / ready sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_init_we   = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (INIT_ON_RESET != 0) begin
          // Gated by rst_n so clock edges while reset is held never touch
          // the array; clearing only happens once the sequence is running.
          w_init_we = rst_n;
          w_cnt_nxt = r_cnt + c_one;
          if (r_cnt == c_last) begin
            w_state_nxt = ST_READY;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_ready   = (r_state == ST_READY);
  assign init_done = w_ready;

  // --------------------------------------------------------------------------
  // Request qualification
  // --------------------------------------------------------------------------
  assign w_wr_in_range = ({1'b0, wr_addr} < c_depth);
  assign w_rd_in_range = ({1'b0, rd_addr} < c_depth);
  assign w_wr_en       = w_ready & wr_cs & w_wr_in_range;
  assign w_rd_en       = w_ready & rd_cs;
  assign w_same_addr   = (wr_addr == rd_addr);

  // --------------------------------------------------------------------------
  // Storage array: no reset, cleared only by the init sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_en) begin
      for (int b = 0; b < BE_SIZE; b++) begin
        if (wr_be[b]) begin
          r_mem[wr_addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read word with write-first bypass: lanes being written this cycle return
  // the new bytes, all other lanes return the stored bytes. Out-of-range
  // reads return zero and never index the array.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      w_rd_word = r_mem[rd_addr];
      if (w_wr_en && w_same_addr) begin
        for (int b = 0; b < BE_SIZE; b++) begin
          if (wr_be[b]) begin
            w_rd_word[8*b +: 8] = wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // First read stage: data only updates on an accepted read so rdata holds
  // its last value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (w_rd_en) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional output pipeline register
  // --------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic                 r_out_valid;
    logic [DATA_SIZE-1:0] r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else begin
        r_out_valid <= r_rd_valid;
        if (r_rd_valid) begin
          r_out_data <= r_rd_data;
        end
      end
    end

    assign rvalid = r_out_valid;
    assign rdata  = r_out_data;
  end else begin : g_no_out_reg
    assign rvalid = r_rd_valid;
    assign rdata  = r_rd_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_mpc_sram_1r1w_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpc_sram_1r1w_be
// Purpose  : Self-checking bench for mpc_sram_1r1w_be. Two instances share
//            one stimulus stream: dut0 uses the defaults (DEPTH=64,
//            OUT_REG=0) and dut1 uses DEPTH=48 with OUT_REG=1. A reference
//            model pushes expected read results into per-instance queues
//            when reads are accepted; a checker pops them when rvalid is
//            due. A vector table covers the directed read/write cases and
//            hand-written sequences cover init latency and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpc_sram_1r1w_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_cs;
  logic [5:0]  rd_addr;
  logic        wr_cs;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_be;
  logic [63:0] wdata;

  logic        init_done0, rvalid0;
  logic [63:0] rdata0;
  logic        init_done1, rvalid1;
  logic [63:0] rdata1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mpc_sram_1r1w_be dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done0),
    .rd_cs     (rd_cs),
    .rd_addr   (rd_addr),
    .rdata     (rdata0),
    .rvalid    (rvalid0),
    .wr_cs     (wr_cs),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wdata     (wdata)
  );

  mpc_sram_1r1w_be #(
    .ADDR_SIZE     (6),
    .DATA_SIZE     (64),
    .DEPTH         (48),
    .OUT_REG       (1),
    .INIT_ON_RESET (1)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done1),
    .rd_cs     (rd_cs),
    .rd_addr   (rd_addr),
    .rdata     (rdata1),
    .rvalid    (rvalid1),
    .wr_cs     (wr_cs),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wdata     (wdata)
  );

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dep(input int k);
    return (k == 0) ? 64 : 48;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  task automatic set_in(input logic rc, input logic [5:0] ra, input logic wc,
                        input logic [5:0] wa, input logic [7:0] be, input logic [63:0] wd);
    rd_cs   = rc;
    rd_addr = ra;
    wr_cs   = wc;
    wr_addr = wa;
    wr_be   = be;
    wdata   = wd;
  endtask

  // --------------------------------------------------------------------------
  // Reference model + scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          e_cnt [2] = '{0, 0};
  bit          mrdy  [2] = '{1'b0, 1'b0};
  logic [63:0] mm    [2][64];

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
          e_cnt[k] = 0;
          mrdy[k]  = 1'b0;
        end
      end else begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
          if (mrdy[k]) begin
            if (rd_cs) begin
              e.data = 64'h0;
              if (int'(rd_addr) < dep(k)) begin
                e.data = mm[k][rd_addr];
                if (wr_cs && wr_addr == rd_addr) e.data = merge(e.data, wdata, wr_be);
              end
              e.due = cyc + k;  // dut0 latency 1, dut1 latency 2
              if (k == 0) q0.push_back(e);
              else        q1.push_back(e);
            end
            if (wr_cs && int'(wr_addr) < dep(k)) begin
              mm[k][wr_addr] = merge(mm[k][wr_addr], wdata, wr_be);
            end
          end else begin
            e_cnt[k]++;
            if (e_cnt[k] == dep(k)) begin
              mrdy[k] = 1'b1;
              for (int a = 0; a < 64; a++) mm[k][a] = 64'h0;
            end
          end
        end
      end
    end
  end

  task automatic sb_check(input int k, input logic v, input logic [63:0] d);
    exp_t e;
    bit   ev;
    ev = 1'b0;
    e.data = 64'h0;
    e.due  = 0;
    if (k == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin ev = 1'b1; e = q0.pop_front(); end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin ev = 1'b1; e = q1.pop_front(); end
    end
    check($sformatf("sb_rvalid%0d", k), {63'h0, v}, {63'h0, ev});
    if (ev && v) check($sformatf("sb_rdata%0d", k), d, e.data);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("init_done0", {63'h0, init_done0}, {63'h0, mrdy[0]});
        check("init_done1", {63'h0, init_done1}, {63'h0, mrdy[1]});
        sb_check(0, rvalid0, rdata0);
        sb_check(1, rvalid1, rdata1);
      end
    end
  end

  // Counts edges after release until each instance reports init_done.
  task automatic wait_init();
    int e  = 0;
    int g0 = -1;
    int g1 = -1;
    while (e < 200 && (g0 < 0 || g1 < 0)) begin
      @(posedge clk);
      e++;
      #1;
      if (init_done0 && g0 < 0) g0 = e;
      if (init_done1 && g1 < 0) g1 = e;
    end
    check("init_lat0", 64'(g0), 64'd64);
    check("init_lat1", 64'(g1), 64'd48);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic        rd_cs;
    logic [5:0]  rd_addr;
    logic        wr_cs;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_be;
    logic [63:0] wdata;
    logic [63:0] exp0;
    logic [63:0] exp1;
  } vec_t;

  vec_t vt [12];

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{1'b0, 6'd0,  1'b1, 6'd5,  8'hFF, 64'h1122334455667788, 64'h0, 64'h0};
    vt[1]  = '{1'b1, 6'd5,  1'b0, 6'd0,  8'h00, 64'h0, 64'h1122334455667788, 64'h1122334455667788};
    vt[2]  = '{1'b1, 6'd5,  1'b1, 6'd5,  8'h0F, 64'hAAAAAAAAAAAAAAAA,
               64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA};
    vt[3]  = '{1'b1, 6'd5,  1'b0, 6'd0,  8'h00, 64'h0, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA};
    vt[4]  = '{1'b0, 6'd0,  1'b1, 6'd50, 8'hFF, 64'hDEADBEEFCAFEF00D, 64'h0, 64'h0};
    vt[5]  = '{1'b1, 6'd50, 1'b0, 6'd0,  8'h00, 64'h0, 64'hDEADBEEFCAFEF00D, 64'h0};
    vt[6]  = '{1'b1, 6'd2,  1'b0, 6'd0,  8'h00, 64'h0, 64'h0, 64'h0};
    vt[7]  = '{1'b1, 6'd7,  1'b1, 6'd2,  8'h81, 64'hFFFFFFFFFFFFFFEE, 64'h0, 64'h0};
    vt[8]  = '{1'b1, 6'd2,  1'b0, 6'd0,  8'h00, 64'h0, 64'hFF000000000000EE, 64'hFF000000000000EE};
    vt[9]  = '{1'b1, 6'd9,  1'b1, 6'd9,  8'h00, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0};
    vt[10] = '{1'b1, 6'd63, 1'b0, 6'd0,  8'h00, 64'h0, 64'h0, 64'h0};
    vt[11] = '{1'b1, 6'd63, 1'b1, 6'd63, 8'hFF, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'h0};

    // Reset state, with a read request held from the start.
    rst_n = 1'b0;
    set_in(1'b1, 6'd0, 1'b0, 6'd0, 8'h00, 64'h0);
    repeat (3) @(negedge clk);
    check("rst_init_done0", {63'h0, init_done0}, 64'h0);
    check("rst_rvalid0",    {63'h0, rvalid0},    64'h0);
    check("rst_rdata0",     rdata0,              64'h0);
    check("rst_init_done1", {63'h0, init_done1}, 64'h0);
    check("rst_rvalid1",    {63'h0, rvalid1},    64'h0);
    check("rst_rdata1",     rdata1,              64'h0);
    rst_n = 1'b1;
    wait_init();

    // Stream reads over every address: all zero after the clear sequence.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      set_in(1'b1, 6'(i), 1'b0, 6'd0, 8'h00, 64'h0);
    end
    @(negedge clk);
    set_in(1'b0, 6'd0, 1'b0, 6'd0, 8'h00, 64'h0);
    repeat (3) @(negedge clk);

    // Directed vectors: dut0 checked one cycle after the edge, dut1 two.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      set_in(vt[i].rd_cs, vt[i].rd_addr, vt[i].wr_cs, vt[i].wr_addr, vt[i].wr_be, vt[i].wdata);
      @(negedge clk);
      check($sformatf("vec%0d_rvalid0", i), {63'h0, rvalid0}, {63'h0, vt[i].rd_cs});
      if (vt[i].rd_cs) check($sformatf("vec%0d_rdata0", i), rdata0, vt[i].exp0);
      set_in(1'b0, 6'd0, 1'b0, 6'd0, 8'h00, 64'h0);
      @(negedge clk);
      check($sformatf("vec%0d_rvalid1", i), {63'h0, rvalid1}, {63'h0, vt[i].rd_cs});
      if (vt[i].rd_cs) check($sformatf("vec%0d_rdata1", i), rdata1, vt[i].exp1);
    end

    // Back-to-back reads 0..63 while writing 63..0 with random lanes.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      set_in(1'b1, 6'(i), 1'b1, 6'(63 - i), 8'($urandom), {$urandom, $urandom});
    end
    @(negedge clk);
    set_in(1'b0, 6'd0, 1'b0, 6'd0, 8'h00, 64'h0);
    repeat (3) @(negedge clk);

    // Async reset with reads in flight, then a reset mid-clear at cnt=30.
    @(negedge clk);
    set_in(1'b1, 6'd5, 1'b0, 6'd0, 8'h00, 64'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rvalid0",    {63'h0, rvalid0},    64'h0);
    check("arst_rvalid1",    {63'h0, rvalid1},    64'h0);
    check("arst_rdata0",     rdata0,              64'h0);
    check("arst_init_done0", {63'h0, init_done0}, 64'h0);
    @(negedge clk);
    set_in(1'b0, 6'd0, 1'b0, 6'd0, 8'h00, 64'h0);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_init_done0", {63'h0, init_done0}, 64'h0);
    check("mid_init_done1", {63'h0, init_done1}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();

    // Previously written words must be cleared.
    @(negedge clk);
    set_in(1'b1, 6'd5, 1'b0, 6'd0, 8'h00, 64'h0);
    @(negedge clk);
    check("post_rst_rvalid5", {63'h0, rvalid0}, 64'h1);
    check("post_rst_rdata5",  rdata0,           64'h0);
    set_in(1'b1, 6'd2, 1'b0, 6'd0, 8'h00, 64'h0);
    @(negedge clk);
    check("post_rst_rdata2",  rdata0,           64'h0);
    check("post_rst1_rdata5", rdata1,           64'h0);
    set_in(1'b0, 6'd0, 1'b0, 6'd0, 8'h00, 64'h0);
    repeat (4) @(negedge clk);

    check("drain0", 64'(q0.size()), 64'h0);
    check("drain1", 64'(q1.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
